// File: rtl/sha256_state_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sha256_state_pipe
// Description : Elastic DEPTH-stage pipeline carrying the SHA-256 working
//               state (a..h) plus a sideband tag between compression round
//               groups. Valid/ready handshake with a combinational ready
//               chain, synchronous flush and an occupancy counter.
//               Optional macro STATE_PIPE_PARITY_EN adds a per-beat even
//               parity bit and a sticky parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_state_pipe #(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 8,
    parameter int DEPTH  = 4,
    parameter int TAGW   = 32,
    parameter logic [NWORDS*WIDTH-1:0] INIT_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NWORDS*WIDTH-1:0]    in_state,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NWORDS*WIDTH-1:0]    out_state,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef STATE_PIPE_PARITY_EN
    ,
    output logic                       parity_err
`endif
);

    localparam int SW_BITS = NWORDS * WIDTH;
    localparam int OCCW    = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]   v_q;
    logic [DEPTH-1:0]   v_d;
    logic [SW_BITS-1:0] state_q [DEPTH];
    logic [TAGW-1:0]    tag_q   [DEPTH];
    logic [OCCW-1:0]    occ_q;
    logic [OCCW-1:0]    occ_d;

    logic [DEPTH-1:0]   w_rdy;
    logic [DEPTH-1:0]   w_vin;
    logic               w_in_fire;
    logic               w_out_fire;

    // Ready chain unrolled top-down: a stage can move if any later stage is empty or downstream accepts
    always_comb begin : p_rdy
        logic acc;
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc      = acc | ~v_q[i];
            w_rdy[i] = acc;
        end
    end

    assign in_ready   = w_rdy[0] & ~flush;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = v_q[DEPTH-1] & out_ready;

    // Next-state of stage valids and occupancy; flush empties every stage
    always_comb begin
        w_vin    = '0;
        w_vin[0] = w_in_fire;
        for (int i = 1; i < DEPTH; i++) begin
            w_vin[i] = v_q[i-1];
        end
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
                v_d[i] = w_vin[i];
            end
        end
        occ_d = occ_q;
        if (w_in_fire && !w_out_fire) begin
            occ_d = occ_q + OCCW'(1);
        end else if (!w_in_fire && w_out_fire) begin
            occ_d = occ_q - OCCW'(1);
        end
        if (flush) begin
            v_d   = '0;
            occ_d = '0;
        end
    end

    // Stage registers; data/tag move only with a valid beat so bubbles never toggle them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= INIT_IV;
                tag_q[i]   <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            if (!flush) begin
                if (w_rdy[0] && w_vin[0]) begin
                    state_q[0] <= in_state;
                    tag_q[0]   <= in_tag;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (w_rdy[i] && w_vin[i]) begin
                        state_q[i] <= state_q[i-1];
                        tag_q[i]   <= tag_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_state = state_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef STATE_PIPE_PARITY_EN
    // Parity of the reset contents, so idle stages stay self-consistent
    localparam logic C_IV_PAR = ^INIT_IV;

    logic [DEPTH-1:0] par_q;
    logic             err_q;

    // Parity bit travels alongside its beat with the same load enables as the data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= {DEPTH{C_IV_PAR}};
        end else if (!flush) begin
            if (w_rdy[0] && w_vin[0]) begin
                par_q[0] <= ^{in_state, in_tag};
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_rdy[i] && w_vin[i]) begin
                    par_q[i] <= par_q[i-1];
                end
            end
        end
    end

    // Sticky error on any valid output beat whose recomputed parity disagrees; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (v_q[DEPTH-1] && ((^{state_q[DEPTH-1], tag_q[DEPTH-1]}) != par_q[DEPTH-1])) begin
            err_q <= 1'b1;
        end
    end

    assign parity_err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_state_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_state_pipe
// Description : Self-checking bench for sha256_state_pipe (default params):
//               reset, streaming latency, full stall, random handshakes,
//               flush and mid-stream reset, all tracked by a tag scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_state_pipe;

    localparam int DEPTH = 4;
    localparam logic [255:0] C_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_state;
    logic [31:0]  in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_state;
    logic [31:0]  out_tag;
    logic [2:0]   occupancy;
`ifdef STATE_PIPE_PARITY_EN
    logic         parity_err;
`endif

    sha256_state_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag),
        .occupancy (occupancy)
`ifdef STATE_PIPE_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          occ_m    = 0;
    int          occ_max  = 0;
    int          n_out    = 0;
    int          first_acc = -1;
    int          first_out = -1;
    bit          mon_en   = 0;
    bit          last_in_fire = 0;
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference state for a tag: every word distinct and tag-dependent
    function automatic logic [255:0] st(input logic [31:0] t);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) begin
            r[255-32*w -: 32] = {t[15:0], 8'(w), 8'hA5} ^ {t[31:16], 16'h0};
        end
        return r;
    endfunction

    // Observe the current cycle mid-period, update the model, advance past the next edge
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        last_in_fire = in_valid && in_ready;
        if (mon_en) begin
            check("occupancy", 256'(occupancy), 256'(occ_m));
            if (32'(occupancy) > occ_max) occ_max = 32'(occupancy);
            if (!rst_n) begin
                occ_m = 0;
                sb_q.delete();
            end else begin
                if (last_in_fire && first_acc < 0) first_acc = cyc;
                if (out_valid && first_out < 0) first_out = cyc;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", 256'(out_tag), 256'hDEAD);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_tag", 256'(out_tag), 256'(e));
                        check("out_state", out_state, st(e));
                    end
                end
                if (flush) begin
                    sb_q.delete();
                    occ_m = 0;
                end else begin
                    if (last_in_fire) sb_q.push_back(in_tag);
                    occ_m = occ_m + (last_in_fire ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] t);
        in_valid = v;
        in_tag   = t;
        in_state = st(t);
    endtask

    initial begin
        int nxt;
        int sent;
        int guard;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(0, 32'h0);

        // ---- reset ----
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_state", out_state, C_IV);
        check("rst_out_tag", 256'(out_tag), 256'(0));
        check("rst_occupancy", 256'(occupancy), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        mon_en = 1;

        // ---- back-to-back stream, tags 0..9 ----
        out_ready = 1'b1;
        first_acc = -1; first_out = -1; occ_max = 0; n_out = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'(k));
            tick();
        end
        drive(0, 32'h0);
        for (int k = 0; k < 8; k++) tick();
        check("stream_latency", 256'(first_out - first_acc), 256'(DEPTH));
        check("stream_occ_max", 256'(occ_max), 256'(DEPTH));
        check("stream_count", 256'(n_out), 256'(10));

        // ---- full stall ----
        out_ready = 1'b0;
        nxt = 100;
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'(nxt));
            tick();
            if (last_in_fire) nxt++;
        end
        check("stall_accepts", 256'(nxt - 100), 256'(DEPTH));
        check("stall_in_ready", 256'(in_ready), 256'(0));
        check("stall_occupancy", 256'(occupancy), 256'(DEPTH));
        check("stall_out_tag", 256'(out_tag), 256'(100));
        check("stall_out_state", out_state, st(32'd100));
        drive(0, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("stall_drained", 256'(sb_q.size()), 256'(0));
        check("stall_occ_after", 256'(occupancy), 256'(0));

        // ---- random bubbles and back-pressure, 200 beats ----
        sent = 0; guard = 0; n_out = 0;
        while (sent < 200 && guard < 5000) begin
            drive(($urandom_range(0, 3) != 0), 32'(1000 + sent));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_in_fire) sent++;
            guard++;
        end
        drive(0, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("rand_sent", 256'(sent), 256'(200));
        check("rand_received", 256'(n_out), 256'(200));
        check("rand_drained", 256'(sb_q.size()), 256'(0));

        // ---- flush with pipe full ----
        out_ready = 1'b0;
        guard = 0;
        while (occupancy != 3'(DEPTH) && guard < 20) begin
            drive(1, 32'(500 + guard));
            tick();
            guard++;
        end
        check("flush_pre_occ", 256'(occupancy), 256'(DEPTH));
        drive(1, 32'h777);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 256'(in_ready), 256'(0));
        tick();
        flush = 1'b0;
        drive(0, 32'h0);
        #1;
        check("flush_out_valid", 256'(out_valid), 256'(0));
        check("flush_occupancy", 256'(occupancy), 256'(0));
        out_ready = 1'b1;
        first_acc = -1; first_out = -1;
        drive(1, 32'h55);
        tick();
        drive(0, 32'h0);
        guard = 0;
        while (first_out < 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("flush_next_latency", 256'(first_out - first_acc), 256'(DEPTH));

        // ---- reset mid-stream with three beats held ----
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'(900 + k));
            tick();
        end
        drive(0, 32'h0);
        #1;
        check("mid_occ_before", 256'(occupancy), 256'(3));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_out_valid", 256'(out_valid), 256'(0));
        check("mid_out_state", out_state, C_IV);
        check("mid_out_tag", 256'(out_tag), 256'(0));
        check("mid_occupancy", 256'(occupancy), 256'(0));
`ifdef STATE_PIPE_PARITY_EN
        check("parity_err", 256'(parity_err), 256'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
